// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2s_pkg
// Brief  : Shared types and width helpers for the I2S/TDM clock generator
//          and the TX/RX shifters that run from its strobes.
// Rev    : 1.0  initial release
// ============================================================================
package i2s_pkg;

  // Serial data format: I2S delays the MSB by one bit clock after the lrclk edge
  typedef enum logic {FMT_I2S = 1'b0, FMT_LJ = 1'b1} i2s_fmt_e;

  // Width of a slot index; never below one bit so ports stay legal
  function automatic int slot_idx_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  // Width of a bit-in-slot index; never below one bit
  function automatic int bit_idx_w(input int slot_bits);
    return (slot_bits > 1) ? $clog2(slot_bits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tdm_clock_gen_if.sv
`default_nettype none
// ============================================================================
// Module : i2s_tdm_clock_gen_if
// Brief  : Control inputs and clock/strobe/position outputs of the generator.
//          slave = generator side, master = consumer/controller side.
//          SLOT_BITS/NUM_SLOTS must match the generator instance.
// Rev    : 1.0  initial release
// ============================================================================
interface i2s_tdm_clock_gen_if #(
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2
) ();
  import i2s_pkg::*;

  localparam int SW = slot_idx_w(NUM_SLOTS);
  localparam int BW = bit_idx_w(SLOT_BITS);

  logic           i_en;
  i2s_fmt_e       i_fmt;
  logic           o_sclk;
  logic           o_lrclk;
  logic           o_sclk_rise;
  logic           o_sclk_fall;
  logic           o_frame_start;
  logic [SW-1:0]  o_slot_idx;
  logic [BW-1:0]  o_bit_idx;

  modport slave (
    input  i_en, i_fmt,
    output o_sclk, o_lrclk, o_sclk_rise, o_sclk_fall, o_frame_start,
           o_slot_idx, o_bit_idx
  );

  modport master (
    output i_en, i_fmt,
    input  o_sclk, o_lrclk, o_sclk_rise, o_sclk_fall, o_frame_start,
           o_slot_idx, o_bit_idx
  );

endinterface
`default_nettype wire

// File: rtl/i2s_frame_counter.sv
`default_nettype none
// ============================================================================
// Module : i2s_frame_counter
// Brief  : Frame position counter split into slot and bit-in-slot fields.
//          Advances on i_adv, wraps at end of frame, i_clr returns to 0.
//          Also exposes the position it would advance to next.
// Rev    : 1.0  initial release
// ============================================================================
module i2s_frame_counter
  import i2s_pkg::*;
#(
  parameter  int SLOT_BITS = 32,
  parameter  int NUM_SLOTS = 2,
  localparam int SW        = slot_idx_w(NUM_SLOTS),
  localparam int BW        = bit_idx_w(SLOT_BITS)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_clr,
  input  wire logic          i_adv,
  output logic [SW-1:0]      o_slot_idx,
  output logic [BW-1:0]      o_bit_idx,
  output logic [SW-1:0]      o_slot_nxt,
  output logic [BW-1:0]      o_bit_nxt,
  output logic               o_wrap
);

  localparam logic [SW-1:0] c_SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [BW-1:0] c_BIT_LAST  = BW'(SLOT_BITS - 1);

  logic [SW-1:0] r_slot;
  logic [BW-1:0] r_bit;
  logic          w_bit_last;
  logic          w_slot_last;

  assign w_bit_last  = (r_bit == c_BIT_LAST);
  assign w_slot_last = (r_slot == c_SLOT_LAST);

  // Next position: bit wraps into the following slot, last slot wraps to 0
  always_comb begin
    o_bit_nxt  = w_bit_last ? '0 : r_bit + 1'b1;
    o_slot_nxt = r_slot;
    if (w_bit_last) begin
      o_slot_nxt = w_slot_last ? '0 : r_slot + 1'b1;
    end
  end

  // Position register; clear wins over advance
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_slot <= '0;
      r_bit  <= '0;
    end else if (i_adv) begin
      r_slot <= o_slot_nxt;
      r_bit  <= o_bit_nxt;
    end
  end

  assign o_slot_idx = r_slot;
  assign o_bit_idx  = r_bit;
  assign o_wrap     = w_bit_last && w_slot_last;

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_clock_gen.sv
`default_nettype none
// ============================================================================
// Module : i2s_tdm_clock_gen
// Brief  : I2S / left-justified / TDM sclk and lrclk generator on mclk, with
//          mclk-wide rise/fall/frame strobes and slot/bit position outputs so
//          shifters can run on mclk with clock enables.
// Rev    : 1.0  initial release
// ============================================================================
module i2s_tdm_clock_gen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV  = 8,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2
) (
  input  wire logic               mclk,
  input  wire logic               rst,
  i2s_tdm_clock_gen_if.slave      bus
);

  if ((MCLK_DIV < 2) || ((MCLK_DIV % 2) != 0)) begin : g_bad_mclk_div
    $error("MCLK_DIV must be even and >= 2");
  end
  if (SLOT_BITS < 2) begin : g_bad_slot_bits
    $error("SLOT_BITS must be >= 2");
  end
  if ((NUM_SLOTS < 2) || ((NUM_SLOTS % 2) != 0)) begin : g_bad_num_slots
    $error("NUM_SLOTS must be even and >= 2");
  end

  localparam int MW = $clog2(MCLK_DIV);
  localparam int SW = slot_idx_w(NUM_SLOTS);
  localparam int BW = bit_idx_w(SLOT_BITS);

  localparam logic [MW-1:0] c_M_LAST    = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] c_M_HALF    = MW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] c_BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] c_SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [SW-1:0] c_SLOT_HALF = SW'(NUM_SLOTS / 2);
  localparam logic [SW:0]   c_SLOT_HALF_X = (SW+1)'(NUM_SLOTS / 2);

  logic [MW-1:0] r_m;
  logic          r_sclk;
  logic          r_rise;
  logic          r_fall;
  logic          r_fs;
  logic          r_lrclk;
  i2s_fmt_e      r_fmt;

  logic [MW-1:0] w_m_nxt;
  logic          w_to_high;
  logic          w_to_low;
  logic          w_adv;
  logic          w_clr;
  logic [SW-1:0] w_slot;
  logic [BW-1:0] w_bit;
  logic [SW-1:0] w_slot_nxt;
  logic [BW-1:0] w_bit_nxt;
  logic [SW:0]   w_slot_nxt_p1;
  logic          w_wrap;
  logic          w_p_zero;
  logic          w_lr_lj;
  logic          w_lr_i2s;
  logic          w_lr_nxt;

  assign w_m_nxt   = (r_m == c_M_LAST) ? '0 : r_m + 1'b1;
  assign w_to_high = (w_m_nxt == c_M_HALF);
  assign w_to_low  = (w_m_nxt == '0);
  assign w_adv     = bus.i_en && w_to_low;
  assign w_clr     = !bus.i_en;
  assign w_p_zero  = (w_slot == '0) && (w_bit == '0);

  i2s_frame_counter #(
    .SLOT_BITS (SLOT_BITS),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_frame_counter (
    .clk        (mclk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_adv      (w_adv),
    .o_slot_idx (w_slot),
    .o_bit_idx  (w_bit),
    .o_slot_nxt (w_slot_nxt),
    .o_bit_nxt  (w_bit_nxt),
    .o_wrap     (w_wrap)
  );

  // lrclk decode on the position being entered: LJ marks the upper half of
  // the slots; I2S looks one bit ahead, so on the last bit of a slot it
  // already reflects the following slot (with the last slot wrapping to 0).
  assign w_slot_nxt_p1 = {1'b0, w_slot_nxt} + 1'b1;
  always_comb begin
    w_lr_lj  = (w_slot_nxt >= c_SLOT_HALF);
    w_lr_i2s = w_lr_lj;
    if (w_bit_nxt == c_BIT_LAST) begin
      w_lr_i2s = (w_slot_nxt != c_SLOT_LAST) && (w_slot_nxt_p1 >= c_SLOT_HALF_X);
    end
    w_lr_nxt = (r_fmt == FMT_LJ) ? w_lr_lj : w_lr_i2s;
  end

  // Divider, bit clock, strobes, lrclk and format latch; idle mirrors reset
  // except that the format keeps tracking the fmt input
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_m     <= '0;
      r_sclk  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_fs    <= 1'b0;
      r_lrclk <= 1'b0;
      r_fmt   <= FMT_I2S;
    end else if (!bus.i_en) begin
      r_m     <= '0;
      r_sclk  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_fs    <= 1'b0;
      r_lrclk <= 1'b0;
      r_fmt   <= bus.i_fmt;
    end else begin
      r_m    <= w_m_nxt;
      r_rise <= w_to_high;
      r_fall <= w_to_low;
      r_fs   <= w_to_high && w_p_zero;
      if (w_to_high) begin
        r_sclk <= 1'b1;
      end else if (w_to_low) begin
        r_sclk <= 1'b0;
      end
      if (w_adv) begin
        r_lrclk <= w_lr_nxt;
        if (w_wrap) begin
          r_fmt <= bus.i_fmt;
        end
      end
    end
  end

  assign bus.o_sclk        = r_sclk;
  assign bus.o_lrclk       = r_lrclk;
  assign bus.o_sclk_rise   = r_rise;
  assign bus.o_sclk_fall   = r_fall;
  assign bus.o_frame_start = r_fs;
  assign bus.o_slot_idx    = w_slot;
  assign bus.o_bit_idx     = w_bit;

endmodule
`default_nettype wire
